measure_sched: RTL

Scan controller for a bank of `measure` frequency-counter channels. It owns each channel's `gate_en_i` and walks the enabled channels one at a time in ascending index order. For each channel it waits for that channel's gated count result, or for a timeout when no signal clock arrives. It then presents the result as a single tagged stream for the register or AXI layer. It supports single-shot and continuous scanning and sits between the AXI register file and the replicated `measure` instances.

---
 rtl/measure_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/measure_sched.sv
// measure_sched: scan controller for a bank of measure frequency-counter channels.
// Walks the enabled channels in ascending order. For each channel it opens the gate,
// then waits for the gated count or for a timeout. Each outcome is reported as one
// tagged result on a shared stream. Single-shot and continuous scanning are supported.
module measure_sched #(
   parameter int          N_CH    = 4,
   parameter int          CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
   parameter logic [31:0] TIMEOUT = 32'd200_000_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 cont_i,
   input  logic [N_CH-1:0]      ch_mask_i,
   input  logic [N_CH-1:0]      gate_sync_i,
   input  logic [N_CH-1:0]      meas_wr_en_i,
   input  logic [64*N_CH-1:0]   meas_wr_data_i,
   output logic [N_CH-1:0]      gate_en_o,
   output logic                 res_valid_o,
   output logic [CH_W-1:0]      res_ch_o,
   output logic [63:0]          res_data_o,
   output logic                 res_timeout_o,
   output logic                 busy_o,
   output logic                 scan_done_o
);

   // The scan pointer needs one extra bit so that it can hold N_CH, which means "past the last channel".
   localparam int PTR_W = CH_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      ARM,
      RUN,
      REPORT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N_CH-1:0]  mask_q, mask_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [31:0]      tmo_cnt_q, tmo_cnt_d;

   logic             found;
   logic [CH_W-1:0]  found_idx;
   logic             sel_sync;
   logic             sel_wr;
   logic [63:0]      sel_data;

   logic [N_CH-1:0]  gate_en_d;
   logic             res_valid_d;
   logic [CH_W-1:0]  res_ch_d;
   logic [63:0]      res_data_d;
   logic             res_timeout_d;
   logic             busy_d;
   logic             scan_done_d;

   // Find the lowest enabled channel at or above the scan pointer.
   // The loop runs downward, so the last match written is the lowest index.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (mask_q[i] && (PTR_W'(i) >= ptr_q)) begin
            found     = 1'b1;
            found_idx = CH_W'(i);
         end
      end
   end

   // Route the handshake and data of the selected channel. Every other channel is invisible here.
   always_comb begin
      sel_sync = 1'b0;
      sel_wr   = 1'b0;
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (CH_W'(i) == ch_q) begin
            sel_sync = gate_sync_i[i];
            sel_wr   = meas_wr_en_i[i];
            sel_data = meas_wr_data_i[64*i +: 64];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Compute the next state and the datapath updates.
   // The outputs are derived from the next state, so every registered output lines up with the state it describes.
   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      ptr_d         = ptr_q;
      ch_d          = ch_q;
      tmo_cnt_d     = tmo_cnt_q;
      res_ch_d      = res_ch_o;
      res_data_d    = res_data_o;
      res_timeout_d = res_timeout_o;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               mask_d  = ch_mask_i;
               ptr_d   = '0;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (found) begin
               ch_d      = found_idx;
               tmo_cnt_d = '0;
               state_d   = ARM;
            end else begin
               state_d = DONE;
            end
         end
         ARM: begin
            if (tmo_cnt_q == TIMEOUT) begin
               res_ch_d      = ch_q;
               res_data_d    = '0;
               res_timeout_d = 1'b1;
               state_d       = REPORT;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
               if (sel_sync) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (sel_wr) begin
               res_ch_d      = ch_q;
               res_data_d    = sel_data;
               res_timeout_d = 1'b0;
               state_d       = REPORT;
            end else if (tmo_cnt_q == TIMEOUT) begin
               res_ch_d      = ch_q;
               res_data_d    = '0;
               res_timeout_d = 1'b1;
               state_d       = REPORT;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
         end
         REPORT: begin
            ptr_d   = PTR_W'(ch_q) + PTR_W'(1);
            state_d = SELECT;
         end
         DONE: begin
            if (cont_i) begin
               mask_d  = ch_mask_i;
               ptr_d   = '0;
               state_d = SELECT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gate_en_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         gate_en_d[i] = (state_d == ARM) && (CH_W'(i) == ch_d);
      end
      res_valid_d = (state_d == REPORT);
      busy_d      = (state_d != IDLE);
      scan_done_d = (state_d == DONE);
   end

   // Register the scan bookkeeping and all outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mask_q        <= '0;
         ptr_q         <= '0;
         ch_q          <= '0;
         tmo_cnt_q     <= '0;
         gate_en_o     <= '0;
         res_valid_o   <= 1'b0;
         res_ch_o      <= '0;
         res_data_o    <= '0;
         res_timeout_o <= 1'b0;
         busy_o        <= 1'b0;
         scan_done_o   <= 1'b0;
      end else begin
         mask_q        <= mask_d;
         ptr_q         <= ptr_d;
         ch_q          <= ch_d;
         tmo_cnt_q     <= tmo_cnt_d;
         gate_en_o     <= gate_en_d;
         res_valid_o   <= res_valid_d;
         res_ch_o      <= res_ch_d;
         res_data_o    <= res_data_d;
         res_timeout_o <= res_timeout_d;
         busy_o        <= busy_d;
         scan_done_o   <= scan_done_d;
      end
   end

endmodule
